// File: rtl/jt900h_useq_if.sv
// Control/status bundle between the JT900H microcode sequencer and its neighbours
// (ucode ROM fields, decoder/ALU/interrupt inputs, sequencer outputs).
interface jt900h_useq_if #(
    parameter int UAW   = 14,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic           cen;
    logic [7:0]     md;
    logic [7:0]     flags;
    logic           zu;
    logic           div_busy;
    logic           mem_busy;
    logic           irq;
    logic [2:0]     int_lvl;
    logic [2:0]     riff;
    logic [2:0]     op;
    logic [1:0]     cond_sel;
    logic           waitmem;
    logic [UAW-1:0] target;

    logic [UAW-1:0] uaddr;
    logic           cc;
    logic [SPW-1:0] sp;
    logic           irq_ack;
    logic           dec_err;

    modport master (
        output cen, md, flags, zu, div_busy, mem_busy, irq, int_lvl, riff,
               op, cond_sel, waitmem, target,
        input  uaddr, cc, sp, irq_ack, dec_err
    );

    modport slave (
        input  cen, md, flags, zu, div_busy, mem_busy, irq, int_lvl, riff,
               op, cond_sel, waitmem, target,
        output uaddr, cc, sp, irq_ack, dec_err
    );
endinterface

// File: rtl/jt900h_useq.sv
// JT900H microcode sequencer: next-address logic, DEPTH-entry return stack, loop register.
// Optional: JT900H_USEQ_OVF_ERR_EN makes stack overflow fatal instead of circular.
module jt900h_useq #(
    parameter int LOW   = 4,
    parameter int UAW   = 14,
    parameter int DEPTH = 4,
    parameter int LCW   = 8,
    parameter logic [UAW-1:0] RST_VEC = 14'h0,
    parameter logic [UAW-1:0] IRQ_VEC = 14'h10
)(
    input  logic          clk,
    input  logic          rst,
    jt900h_useq_if.slave  bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

`ifdef JT900H_USEQ_OVF_ERR_EN
    localparam bit OVF_ERR = 1'b1;
`else
    localparam bit OVF_ERR = 1'b0;
`endif

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JSR  = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_LSET = 3'd4;
    localparam logic [2:0] OP_LOOP = 3'd5;
    localparam logic [2:0] OP_DISP = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [UAW-1:0]            uaddr_q, uaddr_d, lhead_q, lhead_d, nxt;
    logic [SPW-1:0]            sp_q, sp_d;
    logic [LCW-1:0]            lcnt_q, lcnt_d;
    logic [DEPTH-1:0][UAW-1:0] stk_q, stk_d;
    logic                      ack_q, ack_d, err_q, err_d;
    logic                      cc_raw, cc, cond, still, irq_en;
    logic                      f_s, f_z, f_v, f_c;
    logic                      unused_flags;

    assign f_s = bus.flags[7];
    assign f_z = bus.flags[6];
    assign f_v = bus.flags[2];
    assign f_c = bus.flags[0];
    assign unused_flags = ^{bus.flags[5:3], bus.flags[1]};

    // md[3] selects the complemented half of the condition table (0 false / 8 true).
    always_comb begin
        cc_raw = 1'b0;
        case (bus.md[2:0])
            3'd0: cc_raw = 1'b0;
            3'd1: cc_raw = f_s ^ f_v;
            3'd2: cc_raw = f_z | (f_s ^ f_v);
            3'd3: cc_raw = f_z | f_c;
            3'd4: cc_raw = f_v;
            3'd5: cc_raw = f_s;
            3'd6: cc_raw = f_z;
            3'd7: cc_raw = f_c;
            default: cc_raw = 1'b0;
        endcase
        cc = cc_raw ^ bus.md[3];
    end

    always_comb begin
        cond = 1'b1;
        case (bus.cond_sel)
            2'd0: cond = 1'b1;
            2'd1: cond = cc;
            2'd2: cond = ~cc;
            2'd3: cond = ~bus.zu;
            default: cond = 1'b1;
        endcase
    end

    assign nxt    = {uaddr_q[UAW-1:LOW], uaddr_q[LOW-1:0] + LOW'(1)};
    assign still  = bus.div_busy | (bus.waitmem & bus.mem_busy) | err_q;
    assign irq_en = bus.irq && (bus.int_lvl >= bus.riff);

    always_comb begin
        uaddr_d = uaddr_q;
        sp_d    = sp_q;
        lcnt_d  = lcnt_q;
        lhead_d = lhead_q;
        stk_d   = stk_q;
        ack_d   = ack_q;
        err_d   = err_q;
        if (bus.cen) begin
            ack_d = 1'b0;
            if (!still) begin
                case (bus.op)
                    OP_NEXT: uaddr_d = nxt;
                    OP_JMP:  uaddr_d = cond ? bus.target : nxt;
                    OP_JSR: begin
                        if (!cond) begin
                            uaddr_d = nxt;
                        end else if (OVF_ERR && sp_q == SP_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            // Entry 0 is the top; a full stack drops its oldest entry.
                            for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                            stk_d[0] = nxt;
                            uaddr_d  = bus.target;
                            if (sp_q != SP_FULL) sp_d = sp_q + SPW'(1);
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            uaddr_d = stk_q[0];
                            for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                            stk_d[DEPTH-1] = '0;
                            sp_d = sp_q - SPW'(1);
                        end
                    end
                    OP_LSET: begin
                        lcnt_d  = bus.target[LCW-1:0];
                        lhead_d = nxt;
                        uaddr_d = nxt;
                    end
                    OP_LOOP: begin
                        if (lcnt_q != '0) begin
                            lcnt_d  = lcnt_q - LCW'(1);
                            uaddr_d = lhead_q;
                        end else begin
                            uaddr_d = nxt;
                        end
                    end
                    OP_DISP: begin
                        sp_d = '0;
                        if (irq_en) begin
                            uaddr_d = IRQ_VEC;
                            ack_d   = 1'b1;
                        end else begin
                            uaddr_d = {bus.target[1:0], bus.md, {LOW{1'b0}}};
                        end
                    end
                    OP_HALT: begin
                        if (irq_en) begin
                            uaddr_d = IRQ_VEC;
                            ack_d   = 1'b1;
                        end
                    end
                    default: uaddr_d = uaddr_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uaddr_q <= RST_VEC;
            sp_q    <= '0;
            lcnt_q  <= '0;
            lhead_q <= '0;
            stk_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            uaddr_q <= uaddr_d;
            sp_q    <= sp_d;
            lcnt_q  <= lcnt_d;
            lhead_q <= lhead_d;
            stk_q   <= stk_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.uaddr   = uaddr_q;
    assign bus.cc      = cc;
    assign bus.sp      = sp_q;
    assign bus.irq_ack = ack_q;
    assign bus.dec_err = err_q;
endmodule

// File: tb/tb_jt900h_useq.sv
// Bench for jt900h_useq: directed scenarios plus randomized steps against a queue-based model.
module tb_jt900h_useq;
    localparam int DEPTH = 4;
    localparam logic [13:0] IRQ_VEC = 14'h10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt900h_useq_if #(.UAW(14), .DEPTH(DEPTH)) bus();

    jt900h_useq #(.LOW(4), .UAW(14), .DEPTH(DEPTH), .LCW(8),
                  .RST_VEC(14'h0), .IRQ_VEC(IRQ_VEC)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int  m_ua, m_lcnt, m_lhead;
    int  m_stk[$];
    bit  m_ack, m_err;
    int  n_chk = 0, n_fail = 0;

    logic [19:0] obs;
    assign obs = {bus.uaddr, bus.sp, bus.irq_ack, bus.dec_err, bus.cc};

    function automatic bit mcc(input logic [7:0] m, input logic [7:0] f);
        bit s = f[7], z = f[6], v = f[2], c = f[0];
        case (m[3:0])
            4'd0:  return 1'b0;
            4'd1:  return s ^ v;
            4'd2:  return z | (s ^ v);
            4'd3:  return z | c;
            4'd4:  return v;
            4'd5:  return s;
            4'd6:  return z;
            4'd7:  return c;
            4'd8:  return 1'b1;
            4'd9:  return !(s ^ v);
            4'd10: return !(z | (s ^ v));
            4'd11: return !(z | c);
            4'd12: return !v;
            4'd13: return !s;
            4'd14: return !z;
            default: return !c;
        endcase
    endfunction

    function automatic logic [19:0] mexp();
        return {14'(m_ua), 3'(m_stk.size()), m_ack, m_err, mcc(bus.md, bus.flags)};
    endfunction

    // Model of one clock edge from the inputs currently applied.
    task automatic mstep();
        int nx;
        bit cnd, ien;
        if (rst) begin
            m_ua = 0; m_stk.delete(); m_lcnt = 0; m_lhead = 0; m_ack = 0; m_err = 0;
            return;
        end
        if (!bus.cen) return;
        m_ack = 0;
        if (bus.div_busy || (bus.waitmem && bus.mem_busy) || m_err) return;
        nx  = (m_ua & 'h3ff0) | ((m_ua + 1) & 'hf);
        ien = bus.irq && (int'(bus.int_lvl) >= int'(bus.riff));
        case (bus.cond_sel)
            2'd0: cnd = 1;
            2'd1: cnd = mcc(bus.md, bus.flags);
            2'd2: cnd = !mcc(bus.md, bus.flags);
            default: cnd = !bus.zu;
        endcase
        case (bus.op)
            3'd0: m_ua = nx;
            3'd1: m_ua = cnd ? int'(bus.target) : nx;
            3'd2: begin
                if (!cnd) m_ua = nx;
                else if (m_stk.size() == DEPTH) begin
`ifdef JT900H_USEQ_OVF_ERR_EN
                    m_err = 1;
`else
                    void'(m_stk.pop_back());
                    m_stk.push_front(nx);
                    m_ua = int'(bus.target);
`endif
                end else begin
                    m_stk.push_front(nx);
                    m_ua = int'(bus.target);
                end
            end
            3'd3: if (m_stk.size() > 0) m_ua = m_stk.pop_front(); else m_err = 1;
            3'd4: begin m_lcnt = int'(bus.target) & 255; m_lhead = nx; m_ua = nx; end
            3'd5: if (m_lcnt != 0) begin m_lcnt--; m_ua = m_lhead; end else m_ua = nx;
            3'd6: begin
                m_stk.delete();
                if (ien) begin m_ua = IRQ_VEC; m_ack = 1; end
                else m_ua = (int'(bus.target & 3) << 12) | (int'(bus.md) << 4);
            end
            default: if (ien) begin m_ua = IRQ_VEC; m_ack = 1; end
        endcase
    endtask

    task automatic cyc();
        mstep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cen = 1; bus.md = 0; bus.flags = 0; bus.zu = 0; bus.div_busy = 0;
        bus.mem_busy = 0; bus.irq = 0; bus.int_lvl = 0; bus.riff = 0; bus.op = 0;
        bus.cond_sel = 0; bus.waitmem = 0; bus.target = 0;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [13:0] t, input logic [1:0] cs);
        bus.op = o; bus.target = t; bus.cond_sel = cs;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; cyc(); rst = 0;
    endtask

    task automatic test_reset();
        idle();
        bus.cen = 0;
        rst = 1; cyc(); rst = 0;
        n_chk++;
        if (obs !== 20'h0) begin
            n_fail++; $display("FAIL reset_state got %h want %h", obs, 20'h0);
        end
    endtask

    task automatic test_next_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_op(3'd0, 14'h3fff, 2'd0);
            cyc();
            n_chk++;
            if (bus.uaddr !== 14'((i + 1) % 16) || obs !== mexp()) begin
                n_fail++; $display("FAIL next_wrap step %0d got %h want %h", i, obs, mexp());
            end
        end
    endtask

    task automatic test_jsr_ret();
        do_reset();
        set_op(3'd1, 14'h005, 2'd0); cyc();
        set_op(3'd2, 14'h200, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h200 || bus.sp !== 3'd1 || obs !== mexp()) begin
            n_fail++; $display("FAIL jsr got ua=%h sp=%0d want ua=200 sp=1", bus.uaddr, bus.sp);
        end
        set_op(3'd3, 14'h0, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h006 || bus.sp !== 3'd0 || obs !== mexp()) begin
            n_fail++; $display("FAIL ret got ua=%h sp=%0d want ua=006 sp=0", bus.uaddr, bus.sp);
        end
    endtask

    task automatic test_loop();
        int body;
        do_reset();
        set_op(3'd1, 14'h100, 2'd0); cyc();
        set_op(3'd4, 14'h003, 2'd0); cyc();
        body = 0;
        for (int i = 0; i < 10; i++) begin
            set_op(3'd0, 14'h0, 2'd0); cyc();
            body++;
            set_op(3'd5, 14'h0, 2'd0); cyc();
            if (bus.uaddr !== 14'h101) break;
        end
        n_chk++;
        if (body !== 4 || bus.uaddr !== 14'h103 || obs !== mexp()) begin
            n_fail++; $display("FAIL loop body=%0d ua=%h want body=4 ua=103", body, bus.uaddr);
        end
        set_op(3'd5, 14'h0, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h104) begin
            n_fail++; $display("FAIL loop_exhausted got %h want 104", bus.uaddr);
        end
    endtask

    task automatic test_disp();
        do_reset();
        set_op(3'd2, 14'h0020, 2'd0); cyc();
        bus.md = 8'h46;
        set_op(3'd6, 14'h0002, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h2460 || bus.irq_ack !== 1'b0 || bus.sp !== 3'd0) begin
            n_fail++; $display("FAIL disp got %h want ua=2460 ack=0 sp=0", obs);
        end
        bus.irq = 1; bus.int_lvl = 5; bus.riff = 3;
        cyc();
        n_chk++;
        if (bus.uaddr !== IRQ_VEC || bus.irq_ack !== 1'b1) begin
            n_fail++; $display("FAIL disp_irq got ua=%h ack=%b want 0010 1", bus.uaddr, bus.irq_ack);
        end
        bus.irq = 0; set_op(3'd0, 14'h0, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h0011 || bus.irq_ack !== 1'b0) begin
            n_fail++; $display("FAIL irq_ack_pulse got ua=%h ack=%b want 0011 0", bus.uaddr, bus.irq_ack);
        end
        bus.irq = 1; bus.riff = 6;
        set_op(3'd6, 14'h0002, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h2460 || bus.irq_ack !== 1'b0) begin
            n_fail++; $display("FAIL disp_masked got ua=%h ack=%b want 2460 0", bus.uaddr, bus.irq_ack);
        end
        bus.irq = 0;
        set_op(3'd2, 14'h0300, 2'd0); cyc();
        set_op(3'd7, 14'h0, 2'd0); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h0300 || obs !== mexp()) begin
            n_fail++; $display("FAIL halt_hold got %h want %h", obs, mexp());
        end
        bus.irq = 1; bus.int_lvl = 6; bus.riff = 6; cyc();
        n_chk++;
        if (bus.uaddr !== IRQ_VEC || bus.irq_ack !== 1'b1 || bus.sp !== 3'd1) begin
            n_fail++; $display("FAIL halt_irq got %h want ua=0010 ack=1 sp=1", obs);
        end
        bus.irq = 0;
    endtask

    task automatic test_cc();
        for (int i = 0; i < 48; i++) begin
            bus.md = 8'(i); bus.flags = 8'($urandom);
            bus.zu = 1'($urandom); bus.cond_sel = 2'($urandom);
            bus.op = 3'd1; bus.target = 14'($urandom);
            #1;
            n_chk++;
            if (bus.cc !== mcc(bus.md, bus.flags)) begin
                n_fail++; $display("FAIL cc md=%h flags=%h got %b want %b", bus.md, bus.flags, bus.cc, mcc(bus.md, bus.flags));
            end
            cyc();
            n_chk++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL cond_jmp got %h want %h", obs, mexp());
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_op(3'd1, 14'h0333, 2'd0);
        bus.div_busy = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_chk++;
            if (bus.uaddr !== 14'h0) begin
                n_fail++; $display("FAIL div_stall cycle %0d got %h want 0000", i, bus.uaddr);
            end
        end
        bus.div_busy = 0; cyc();
        n_chk++;
        if (bus.uaddr !== 14'h0333) begin
            n_fail++; $display("FAIL div_release got %h want 0333", bus.uaddr);
        end
        set_op(3'd0, 14'h0, 2'd0); bus.waitmem = 1; bus.mem_busy = 1; cyc(); cyc();
        n_chk++;
        if (bus.uaddr !== 14'h0333) begin
            n_fail++; $display("FAIL mem_stall got %h want 0333", bus.uaddr);
        end
        bus.waitmem = 0; cyc();
        n_chk++;
        if (bus.uaddr !== 14'h0334) begin
            n_fail++; $display("FAIL mem_ignored got %h want 0334", bus.uaddr);
        end
        bus.mem_busy = 0; bus.cen = 0; cyc();
        n_chk++;
        if (bus.uaddr !== 14'h0334) begin
            n_fail++; $display("FAIL cen_low got %h want 0334", bus.uaddr);
        end
        bus.cen = 1;
    endtask

    task automatic test_nest();
        logic [13:0] want;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_op(3'd2, 14'(i * 'h100), 2'd0); cyc();
        end
`ifdef JT900H_USEQ_OVF_ERR_EN
        n_chk++;
        if (bus.dec_err !== 1'b1 || bus.sp !== 3'd4 || bus.uaddr !== 14'h0400) begin
            n_fail++; $display("FAIL ovf_err got %h want ua=0400 sp=4 err=1", obs);
        end
`else
        n_chk++;
        if (bus.dec_err !== 1'b0 || bus.sp !== 3'd4 || bus.uaddr !== 14'h0500) begin
            n_fail++; $display("FAIL ovf_wrap got %h want ua=0500 sp=4 err=0", obs);
        end
        for (int i = 4; i >= 1; i--) begin
            set_op(3'd3, 14'h0, 2'd0); cyc();
            want = 14'(i * 'h100 + 1);
            n_chk++;
            if (bus.uaddr !== want || obs !== mexp()) begin
                n_fail++; $display("FAIL ret_chain got %h want %h", bus.uaddr, want);
            end
        end
        cyc();
        n_chk++;
        if (bus.dec_err !== 1'b1 || bus.uaddr !== 14'h0101) begin
            n_fail++; $display("FAIL underflow got %h want ua=0101 err=1", obs);
        end
`endif
        set_op(3'd0, 14'h0, 2'd0); cyc(); cyc();
        n_chk++;
        if (bus.dec_err !== 1'b1 || obs !== mexp()) begin
            n_fail++; $display("FAIL err_freeze got %h want %h", obs, mexp());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_err && ($urandom % 4 == 0)) begin
                do_reset();
                continue;
            end
            bus.cen      = ($urandom % 5) != 0;
            bus.md       = 8'($urandom);
            bus.flags    = 8'($urandom);
            bus.zu       = 1'($urandom);
            bus.div_busy = ($urandom % 8) == 0;
            bus.mem_busy = 1'($urandom);
            bus.waitmem  = ($urandom % 4) == 0;
            bus.irq      = ($urandom % 3) == 0;
            bus.int_lvl  = 3'($urandom);
            bus.riff     = 3'($urandom);
            bus.op       = 3'($urandom);
            bus.cond_sel = 2'($urandom);
            bus.target   = 14'($urandom);
            if (bus.op == 3'd4) bus.target[7:0] = 8'($urandom_range(0, 3));
            cyc();
            n_chk++;
            if (obs !== mexp()) begin
                n_fail++; $display("FAIL random step %0d op=%0d got %h want %h", i, bus.op, obs, mexp());
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_next_wrap();
        test_jsr_ret();
        test_loop();
        test_disp();
        test_cc();
        test_stall();
        test_nest();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jt900h_useq.md
Name: jt900h_useq

Overview:
- Parametrised microcode sequencer for the JT900H core.
- Computes the next microcode address from a per-step opcode supplied by the ucode ROM.
- Generalises the single-level return register of the previous control block into a DEPTH-entry return stack, plus a dedicated down-counting loop register.
- Sits between the ucode ROM (which it addresses) and the instruction decoder, interrupt controller and ALU (which supply md, flags and zu).

Parameters:
LOW, 4, width of the low (step) field of the microaddress; the field increments with wrap
UAW, 14, microaddress width; must equal LOW+10 (2-bit group, 8-bit opcode md, LOW step bits)
DEPTH, 4, return-stack entries (1..16)
LCW, 8, loop-counter width (LCW <= UAW)
RST_VEC, 14'h0, microaddress loaded at reset
IRQ_VEC, 14'h10, microaddress entered when an interrupt is accepted

Ports:
clk  in  1  clock
rst  in  1  reset
cen  in  1  clock enable; no state changes when low
md  in  8  current opcode byte
flags  in  8  S,Z,-,H,-,V,N,C at bits 7..0
zu  in  1  zero flag from ALU
div_busy  in  1  divider busy
mem_busy  in  1  bus busy
irq  in  1  interrupt request
int_lvl  in  3  request level
riff  in  3  current interrupt mask
op  in  3  0 NEXT, 1 JMP, 2 JSR, 3 RET, 4 LSET, 5 LOOP, 6 DISP, 7 HALT
cond_sel  in  2  0 always, 1 cc, 2 !cc, 3 !zu
waitmem  in  1  step must wait for mem_busy
target  in  UAW  jump/call address; low LCW bits = LSET count; low 2 bits = DISP group
uaddr  out  UAW  current microaddress (registered)
cc  out  1  condition code (combinational)
sp  out  $clog2(DEPTH+1)  stack occupancy
irq_ack  out  1  one-cycle pulse when an interrupt is taken
dec_err  out  1  sticky fatal error

Behaviour:
- Reset: synchronous, active-high, takes precedence over cen. uaddr=RST_VEC, sp=0, lcnt=0, lhead=0, irq_ack=0, dec_err=0.
- cc from md[3:0]:
  - 0 false; 1 S^V; 2 Z|(S^V); 3 Z|C; 4 V; 5 S; 6 Z; 7 C
  - 8 true; 9..15 are the complements of 1..7
- cond: true if cond_sel=0; cc if 1; !cc if 2; !zu if 3.
- nxt = {uaddr[UAW-1:LOW], uaddr[LOW-1:0]+1}. The step field wraps; group and opcode bits are never carried into.
- still = div_busy | (waitmem & mem_busy) | dec_err. While still, every register holds and irq_ack=0.
- irq_en = irq && int_lvl >= riff.
- Per cen cycle when not still:
  - NEXT: uaddr<=nxt.
  - JMP: uaddr<=cond?target:nxt.
  - JSR: if cond, push nxt and uaddr<=target; else uaddr<=nxt.
  - RET: if sp>0, pop into uaddr. If sp==0 (underflow), dec_err<=1 and uaddr holds.
  - LSET: lcnt<=target[LCW-1:0], lhead<=nxt, uaddr<=nxt.
  - LOOP: if lcnt!=0, lcnt<=lcnt-1 and uaddr<=lhead; else uaddr<=nxt. LSET with count N runs the body N+1 times.
  - DISP: if irq_en, uaddr<=IRQ_VEC, irq_ack<=1, sp<=0. Else uaddr<={target[1:0], md, LOW'b0}, sp<=0.
  - HALT: uaddr holds. If irq_en, uaddr<=IRQ_VEC and irq_ack<=1; the stack is untouched.
- irq_ack is 1 for exactly one cen cycle and 0 otherwise.
- Stack push when sp==DEPTH (overflow): see Optional Feature.
- Push and pop are never simultaneous; single op per step.
- dec_err is sticky until rst; uaddr freezes once it is set.

Optional Feature:
JT900H_USEQ_OVF_ERR_EN
- Defined: a push at sp==DEPTH sets dec_err; uaddr and the stack hold.
- Undefined: the stack is circular. The oldest entry is overwritten, sp saturates at DEPTH, and the call proceeds normally. Underflow always sets dec_err in both builds.

Test Plan:
- rst high 1 cycle, then op=NEXT x20 from RST_VEC=0 -> uaddr 0,1,...,15,0 (step field wraps, upper bits stay 0).
- uaddr=0x005, op=JSR, target=0x200, cond_sel=0; then op=RET -> uaddr 0x200 then 0x006; sp 1 then 0.
- op=LSET, target=3; body NEXT; then LOOP -> body executes 4 times, then falls through; lcnt ends at 0.
- md=0x46, group 2, op=DISP, irq=0 -> uaddr={2,0x46,0}=0x2460. Repeat with irq=1, int_lvl=5, riff=3 -> uaddr=IRQ_VEC, irq_ack high 1 cycle. With riff=6 -> no interrupt is taken.
- div_busy=1 for 5 cycles during JMP -> uaddr holds 5 cycles, then jumps. waitmem=1 with mem_busy=1 -> holds; waitmem=0 -> ignores mem_busy.
- DEPTH=4, 5 nested JSR -> macro defined: dec_err=1, sp=4. Undefined: sp=4, 4 RETs return to the 5th,4th,3rd,2nd callers, and a 5th RET sets dec_err.
